// File: rtl/stream_pack_unpack.sv
// Gearbox for the ed25519 core boundary: packs DATA_W-bit beats into a wide
// operand word and unpacks a wide result word back into DATA_W-bit beats.
module stream_pack_unpack #(
  parameter int DATA_W    = 64,
  parameter int IN_BEATS  = 12,
  parameter int OUT_BEATS = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_in_valid,
  output logic                        o_in_ready,
  input  logic [DATA_W-1:0]           i_in_data,
  output logic                        o_pkt_valid,
  input  logic                        i_pkt_ready,
  output logic [IN_BEATS*DATA_W-1:0]  o_pkt_data,
  input  logic                        i_res_valid,
  output logic                        o_res_ready,
  input  logic [OUT_BEATS*DATA_W-1:0] i_res_data,
  output logic                        o_out_valid,
  input  logic                        i_out_ready,
  output logic [DATA_W-1:0]           o_out_data
);

  localparam int RES_W = OUT_BEATS * DATA_W;
  localparam int ICW   = (IN_BEATS > 1) ? $clog2(IN_BEATS) : 1;
  localparam int OCW   = (OUT_BEATS > 1) ? $clog2(OUT_BEATS) : 1;
  localparam logic [ICW-1:0] LAST_IN  = ICW'(IN_BEATS - 1);
  localparam logic [OCW-1:0] LAST_OUT = OCW'(OUT_BEATS - 1);

  typedef enum logic {COLLECT, HOLD} pack_state_e;
  typedef enum logic {IDLE, SEND} unpack_state_e;

  // ---------------- pack side ----------------
  pack_state_e      pack_state_q, pack_state_d;
  logic [ICW-1:0]   in_cnt_q, in_cnt_d;
  logic             in_fire;

  always_comb begin
    pack_state_d = pack_state_q;
    in_cnt_d     = in_cnt_q;
    o_in_ready   = 1'b0;
    o_pkt_valid  = 1'b0;
    case (pack_state_q)
      COLLECT: o_in_ready = 1'b1;
      HOLD: begin
        o_pkt_valid = 1'b1;
        o_in_ready  = i_pkt_ready;
        if (i_pkt_ready) pack_state_d = COLLECT;
      end
      default: pack_state_d = COLLECT;
    endcase
    in_fire = i_in_valid & o_in_ready;
    // A beat taken during the packet handoff is counted from slot 0 (in_cnt_q is 0 in HOLD)
    if (in_fire) begin
      if (in_cnt_q == LAST_IN) begin
        in_cnt_d     = '0;
        pack_state_d = HOLD;
      end else begin
        in_cnt_d = in_cnt_q + ICW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pack_state_q <= COLLECT;
      in_cnt_q     <= '0;
    end else begin
      pack_state_q <= pack_state_d;
      in_cnt_q     <= in_cnt_d;
    end
  end

  generate
    for (genvar gi = 0; gi < IN_BEATS; gi++) begin : g_slot
      localparam logic [ICW-1:0] BEAT = (MSB_FIRST != 0) ? ICW'(IN_BEATS - 1 - gi) : ICW'(gi);
      logic [DATA_W-1:0] slot_q;
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          slot_q <= '0;
        end else if (in_fire && (in_cnt_q == BEAT)) begin
          slot_q <= i_in_data;
        end
      end
      assign o_pkt_data[gi*DATA_W +: DATA_W] = slot_q;
    end
  endgenerate

  // ---------------- unpack side ----------------
  unpack_state_e    unpack_state_q, unpack_state_d;
  logic [OCW-1:0]   out_cnt_q, out_cnt_d;
  logic [RES_W-1:0] shreg_q, shreg_d;
  logic             out_fire;
  logic             last_beat;

  always_comb begin
    unpack_state_d = unpack_state_q;
    out_cnt_d      = out_cnt_q;
    shreg_d        = shreg_q;
    o_out_valid    = (unpack_state_q == SEND);
    last_beat      = (out_cnt_q == LAST_OUT);
    out_fire       = o_out_valid & i_out_ready;
    // Ready for the next result while the final beat leaves: no idle cycle between results
    o_res_ready    = (unpack_state_q == IDLE) | (o_out_valid & last_beat & i_out_ready);
    if (out_fire) begin
      shreg_d = (MSB_FIRST != 0) ? (shreg_q << DATA_W) : (shreg_q >> DATA_W);
      if (last_beat) begin
        out_cnt_d      = '0;
        unpack_state_d = IDLE;
      end else begin
        out_cnt_d = out_cnt_q + OCW'(1);
      end
    end
    if (i_res_valid && o_res_ready) begin
      shreg_d        = i_res_data;
      out_cnt_d      = '0;
      unpack_state_d = SEND;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      unpack_state_q <= IDLE;
      out_cnt_q      <= '0;
      shreg_q        <= '0;
    end else begin
      unpack_state_q <= unpack_state_d;
      out_cnt_q      <= out_cnt_d;
      shreg_q        <= shreg_d;
    end
  end

  // Zero fill on shift makes the output slice read 0 once the register drains
  assign o_out_data = (MSB_FIRST != 0) ? shreg_q[RES_W-1 -: DATA_W] : shreg_q[DATA_W-1:0];

endmodule

// File: tb/tb_stream_pack_unpack.sv
// Directed self-checking bench: default 64x12/8 MSB-first gearbox plus a
// 32-bit, 3-in / 2-out LSB-first instance.
module tb_stream_pack_unpack;

  logic         i_clk;
  logic         i_rst;
  logic         i_in_valid;
  logic         o_in_ready;
  logic [63:0]  i_in_data;
  logic         o_pkt_valid;
  logic         i_pkt_ready;
  logic [767:0] o_pkt_data;
  logic         i_res_valid;
  logic         o_res_ready;
  logic [511:0] i_res_data;
  logic         o_out_valid;
  logic         i_out_ready;
  logic [63:0]  o_out_data;

  logic         b_in_valid;
  logic         b_in_ready;
  logic [31:0]  b_in_data;
  logic         b_pkt_valid;
  logic         b_pkt_ready;
  logic [95:0]  b_pkt_data;
  logic         b_res_valid;
  logic         b_res_ready;
  logic [63:0]  b_res_data;
  logic         b_out_valid;
  logic         b_out_ready;
  logic [31:0]  b_out_data;

  int n_cmp = 0;
  int n_err = 0;

  stream_pack_unpack dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_data(i_in_data),
    .o_pkt_valid(o_pkt_valid), .i_pkt_ready(i_pkt_ready), .o_pkt_data(o_pkt_data),
    .i_res_valid(i_res_valid), .o_res_ready(o_res_ready), .i_res_data(i_res_data),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_data(o_out_data)
  );

  stream_pack_unpack #(.DATA_W(32), .IN_BEATS(3), .OUT_BEATS(2), .MSB_FIRST(0)) dut_lsb (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_in_valid(b_in_valid), .o_in_ready(b_in_ready), .i_in_data(b_in_data),
    .o_pkt_valid(b_pkt_valid), .i_pkt_ready(b_pkt_ready), .o_pkt_data(b_pkt_data),
    .i_res_valid(b_res_valid), .o_res_ready(b_res_ready), .i_res_data(b_res_data),
    .o_out_valid(b_out_valid), .i_out_ready(b_out_ready), .o_out_data(b_out_data)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    n_cmp++;
    if (o_in_ready !== 1'b1 || o_pkt_valid !== 1'b0 || o_pkt_data !== 768'd0 ||
        o_res_ready !== 1'b1 || o_out_valid !== 1'b0 || o_out_data !== 64'd0) begin
      n_err++;
      $display("FAIL %s: in_rdy=%b pkt_v=%b pkt_nz=%b res_rdy=%b out_v=%b out=%h required 1 0 0 1 0 0",
               tag, o_in_ready, o_pkt_valid, (o_pkt_data != 0), o_res_ready, o_out_valid, o_out_data);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    tick();
    tick();
    i_rst = 1'b0;
    check_reset_values("reset_values");
    n_cmp++;
    if (b_in_ready !== 1'b1 || b_pkt_valid !== 1'b0 || b_pkt_data !== 96'd0 ||
        b_res_ready !== 1'b1 || b_out_valid !== 1'b0 || b_out_data !== 32'd0) begin
      n_err++;
      $display("FAIL reset_values_lsb: in_rdy=%b pkt_v=%b pkt=%h res_rdy=%b out_v=%b out=%h",
               b_in_ready, b_pkt_valid, b_pkt_data, b_res_ready, b_out_valid, b_out_data);
    end
    $display("reset applied");
  endtask

  // 12 beats, MSB first; pkt_ready held low so the packet stays observable in HOLD
  task automatic test_pack(output logic [767:0] exp_pkt);
    logic [63:0] beat;
    exp_pkt = '0;
    i_pkt_ready = 1'b0;
    for (int k = 0; k < 12; k++) begin
      beat = 64'h1111_1111_1111_1111 * 64'(k + 1);
      exp_pkt[(11 - k) * 64 +: 64] = beat;
      i_in_valid = 1'b1;
      i_in_data  = beat;
      #1;
      n_cmp++;
      if (o_pkt_valid !== 1'b0 || o_in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL pack_early_valid beat %0d: pkt_v=%b in_rdy=%b required 0 1", k, o_pkt_valid, o_in_ready);
      end
      tick();
    end
    i_in_valid = 1'b0;
    n_cmp++;
    if (o_pkt_valid !== 1'b1) begin
      n_err++;
      $display("FAIL pack_valid_latency: pkt_v=%b required 1", o_pkt_valid);
    end
    n_cmp++;
    if (o_pkt_data[767:704] !== 64'h1111_1111_1111_1111) begin
      n_err++;
      $display("FAIL pack_top_beat: got %h required 1111111111111111", o_pkt_data[767:704]);
    end
    n_cmp++;
    if (o_pkt_data !== exp_pkt) begin
      n_err++;
      $display("FAIL pack_full: low beat %h required %h", o_pkt_data[63:0], exp_pkt[63:0]);
    end
    $display("packet 1 assembled, low beat %h", o_pkt_data[63:0]);
  endtask

  task automatic test_hold(input logic [767:0] held);
    logic [767:0] exp_pkt;
    exp_pkt = '0;
    for (int c = 0; c < 5; c++) begin
      i_pkt_ready = 1'b0;
      i_in_valid  = (c == 2);
      i_in_data   = 64'hDEAD_BEEF_DEAD_BEEF;
      #1;
      n_cmp++;
      if (o_in_ready !== 1'b0 || o_pkt_valid !== 1'b1 || o_pkt_data !== held) begin
        n_err++;
        $display("FAIL hold_cycle %0d: in_rdy=%b pkt_v=%b data_changed=%b required 0 1 0",
                 c, o_in_ready, o_pkt_valid, (o_pkt_data != held));
      end
      tick();
    end
    i_pkt_ready = 1'b1;
    i_in_valid  = 1'b1;
    i_in_data   = 64'hA5A5_A5A5_A5A5_A5A5;
    #1;
    n_cmp++;
    if (o_in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL hold_fastpath_ready: in_rdy=%b required 1", o_in_ready);
    end
    tick();
    i_pkt_ready = 1'b0;
    exp_pkt[767:704] = 64'hA5A5_A5A5_A5A5_A5A5;
    n_cmp++;
    if (o_pkt_valid !== 1'b0 || o_pkt_data[767:704] !== 64'hA5A5_A5A5_A5A5_A5A5) begin
      n_err++;
      $display("FAIL hold_handoff: pkt_v=%b top=%h required 0 a5a5a5a5a5a5a5a5", o_pkt_valid, o_pkt_data[767:704]);
    end
    for (int k = 1; k < 12; k++) begin
      i_in_data = 64'h0000_0000_0000_0100 + 64'(k);
      exp_pkt[(11 - k) * 64 +: 64] = i_in_data;
      tick();
    end
    i_in_valid = 1'b0;
    n_cmp++;
    if (o_pkt_valid !== 1'b1 || o_pkt_data !== exp_pkt) begin
      n_err++;
      $display("FAIL hold_next_packet: pkt_v=%b top=%h low=%h required 1 a5a5a5a5a5a5a5a5 %h",
               o_pkt_valid, o_pkt_data[767:704], o_pkt_data[63:0], exp_pkt[63:0]);
    end
    $display("packet 2 assembled, top beat %h", o_pkt_data[767:704]);
    i_pkt_ready = 1'b1;
    tick();
    i_pkt_ready = 1'b0;
    n_cmp++;
    if (o_pkt_valid !== 1'b0 || o_pkt_data !== exp_pkt) begin
      n_err++;
      $display("FAIL hold_release: pkt_v=%b data_kept=%b required 0 1", o_pkt_valid, (o_pkt_data == exp_pkt));
    end
  endtask

  task automatic test_unpack();
    int idx;
    int cycles;
    int unsigned r;
    logic rdy;
    for (int j = 0; j < 8; j++) i_res_data[(7 - j) * 64 +: 64] = 64'(j);
    i_res_valid = 1'b1;
    i_out_ready = 1'b0;
    tick();
    i_res_valid = 1'b0;
    r = $urandom(1);
    idx = 0;
    cycles = 0;
    while (idx < 8 && cycles < 200) begin
      n_cmp++;
      if (o_out_valid !== 1'b1 || o_out_data !== 64'(idx)) begin
        n_err++;
        $display("FAIL unpack_beat %0d: out_v=%b out=%h required 1 %h", idx, o_out_valid, o_out_data, 64'(idx));
      end
      rdy = 1'($urandom_range(0, 1));
      i_out_ready = rdy;
      tick();
      if (rdy) begin
        $display("out beat %0d = %h", idx, 64'(idx));
        idx++;
      end
      cycles++;
    end
    i_out_ready = 1'b0;
    n_cmp++;
    if (idx != 8) begin
      n_err++;
      $display("FAIL unpack_timeout: beats=%0d required 8", idx);
    end
    n_cmp++;
    if (o_out_valid !== 1'b0 || o_out_data !== 64'd0 || o_res_ready !== 1'b1) begin
      n_err++;
      $display("FAIL unpack_idle: out_v=%b out=%h res_rdy=%b required 0 0 1", o_out_valid, o_out_data, o_res_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_beat;
    for (int j = 0; j < 8; j++) i_res_data[(7 - j) * 64 +: 64] = 64'h10 + 64'(j);
    i_res_valid = 1'b1;
    i_out_ready = 1'b1;
    tick();
    for (int j = 0; j < 8; j++) i_res_data[(7 - j) * 64 +: 64] = 64'h20 + 64'(j);
    for (int b = 0; b < 16; b++) begin
      exp_beat = (b < 8) ? (64'h10 + 64'(b)) : (64'h20 + 64'(b - 8));
      n_cmp++;
      if (o_out_valid !== 1'b1 || o_out_data !== exp_beat || o_res_ready !== ((b % 8) == 7)) begin
        n_err++;
        $display("FAIL b2b_beat %0d: out_v=%b out=%h res_rdy=%b required 1 %h %b",
                 b, o_out_valid, o_out_data, o_res_ready, exp_beat, ((b % 8) == 7));
      end
      tick();
      if (b == 7) i_res_valid = 1'b0;
    end
    i_out_ready = 1'b0;
    n_cmp++;
    if (o_out_valid !== 1'b0 || o_out_data !== 64'd0) begin
      n_err++;
      $display("FAIL b2b_end: out_v=%b out=%h required 0 0", o_out_valid, o_out_data);
    end
    $display("back-to-back results streamed, 16 beats");
  endtask

  task automatic test_reset_mid();
    logic [767:0] exp_pkt;
    exp_pkt = '0;
    i_pkt_ready = 1'b0;
    i_in_valid  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      i_in_data = 64'hFFFF_0000_0000_0000 + 64'(k);
      tick();
    end
    i_in_valid = 1'b0;
    for (int j = 0; j < 8; j++) i_res_data[(7 - j) * 64 +: 64] = 64'h30 + 64'(j);
    i_res_valid = 1'b1;
    tick();
    i_res_valid = 1'b0;
    i_out_ready = 1'b1;
    tick();
    tick();
    tick();
    i_out_ready = 1'b0;
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check_reset_values("reset_mid_values");
    i_in_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      i_in_data = 64'h200 + 64'(k);
      exp_pkt[(11 - k) * 64 +: 64] = i_in_data;
      tick();
    end
    i_in_valid = 1'b0;
    n_cmp++;
    if (o_pkt_valid !== 1'b1 || o_pkt_data !== exp_pkt) begin
      n_err++;
      $display("FAIL reset_mid_repack: pkt_v=%b top=%h low=%h required 1 %h %h",
               o_pkt_valid, o_pkt_data[767:704], o_pkt_data[63:0], exp_pkt[767:704], exp_pkt[63:0]);
    end
    n_cmp++;
    if (o_out_valid !== 1'b0 || o_out_data !== 64'd0) begin
      n_err++;
      $display("FAIL reset_mid_unpack: out_v=%b out=%h required 0 0", o_out_valid, o_out_data);
    end
    $display("packet after mid-reset assembled");
    i_pkt_ready = 1'b1;
    tick();
    i_pkt_ready = 1'b0;
  endtask

  task automatic test_lsb_first();
    b_in_valid = 1'b1;
    b_in_data  = 32'd1;
    tick();
    b_in_data  = 32'd2;
    tick();
    b_in_data  = 32'd3;
    tick();
    b_in_valid = 1'b0;
    n_cmp++;
    if (b_pkt_valid !== 1'b1 || b_pkt_data !== 96'h00000003_00000002_00000001) begin
      n_err++;
      $display("FAIL lsb_pack: pkt_v=%b data=%h required 1 000000030000000200000001", b_pkt_valid, b_pkt_data);
    end
    $display("lsb packet %h", b_pkt_data);
    b_pkt_ready = 1'b1;
    tick();
    b_pkt_ready = 1'b0;
    b_res_data  = 64'h0000000B_0000000A;
    b_res_valid = 1'b1;
    tick();
    b_res_valid = 1'b0;
    b_out_ready = 1'b1;
    n_cmp++;
    if (b_out_valid !== 1'b1 || b_out_data !== 32'h0000000A) begin
      n_err++;
      $display("FAIL lsb_unpack_beat0: out_v=%b out=%h required 1 0000000a", b_out_valid, b_out_data);
    end
    tick();
    n_cmp++;
    if (b_out_valid !== 1'b1 || b_out_data !== 32'h0000000B) begin
      n_err++;
      $display("FAIL lsb_unpack_beat1: out_v=%b out=%h required 1 0000000b", b_out_valid, b_out_data);
    end
    tick();
    b_out_ready = 1'b0;
    n_cmp++;
    if (b_out_valid !== 1'b0 || b_out_data !== 32'd0) begin
      n_err++;
      $display("FAIL lsb_unpack_idle: out_v=%b out=%h required 0 0", b_out_valid, b_out_data);
    end
  endtask

  initial begin
    logic [767:0] pkt1;
    i_rst = 1'b0;
    i_in_valid = 1'b0;  i_in_data = '0;  i_pkt_ready = 1'b0;
    i_res_valid = 1'b0; i_res_data = '0; i_out_ready = 1'b0;
    b_in_valid = 1'b0;  b_in_data = '0;  b_pkt_ready = 1'b0;
    b_res_valid = 1'b0; b_res_data = '0; b_out_ready = 1'b0;
    test_reset();
    test_pack(pkt1);
    test_hold(pkt1);
    test_unpack();
    test_back_to_back();
    test_reset_mid();
    test_lsb_first();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stream_pack_unpack.md
Name: stream_pack_unpack

Overview:
- Parametrised I/O gearbox for the ed25519 core boundary: packs a stream of DATA_W-bit beats into one wide operand word, and unpacks a wide result word back into DATA_W-bit beats.
- Both sides use valid/ready handshakes and tolerate arbitrary back-pressure (random valid/ready on every port).
- Generalises the fixed 64-bit, 12-in / 8-out framing to any width, beat count and beat order, and supports back-to-back packets with no bubble.

Parameters:
- DATA_W, 64, beat width in bits
- IN_BEATS, 12, beats per packed input packet (3 x 256-bit operands)
- OUT_BEATS, 8, beats per unpacked result (2 x 256-bit coordinates)
- MSB_FIRST, 1, 1: first beat is the most significant; 0: first beat is the least significant (both sides)

Ports:
- i_clk, in, 1, clock
- i_rst, in, 1, synchronous active-high reset
- i_in_valid, in, 1, input beat valid
- o_in_ready, out, 1, input beat ready
- i_in_data, in, DATA_W, input beat
- o_pkt_valid, out, 1, packed packet valid
- i_pkt_ready, in, 1, packed packet accepted by core
- o_pkt_data, out, IN_BEATS*DATA_W, packed packet
- i_res_valid, in, 1, core result valid
- o_res_ready, out, 1, result accepted by gearbox
- i_res_data, in, OUT_BEATS*DATA_W, core result
- o_out_valid, out, 1, output beat valid
- i_out_ready, in, 1, output beat ready
- o_out_data, out, DATA_W, output beat

Behaviour:
- Clock and reset: one clock, i_clk, rising edge. Reset i_rst is synchronous and active-high.
- Handshake: a transfer occurs on a rising edge where valid & ready are both 1. A valid signal never depends combinationally on the matching ready. Data is held stable while valid=1 and ready=0.
- Reset values: o_in_ready=1, o_pkt_valid=0, o_pkt_data=0, o_res_ready=1, o_out_valid=0, o_out_data=0. All beat counters are 0.
- Reset asserted mid-operation discards any partial or held packet and any unsent result beats. Both FSMs return to their first state on the next edge.
- Pack FSM states: COLLECT, HOLD.
  - COLLECT: o_in_ready=1. Each accepted beat is written into slot in_cnt and in_cnt increments.
  - MSB_FIRST=1: beat k goes to bits [(IN_BEATS-1-k)*DATA_W +: DATA_W]. MSB_FIRST=0: beat k goes to [k*DATA_W +: DATA_W].
  - Acceptance of beat IN_BEATS-1 causes in_cnt to wrap to 0, the FSM to move to HOLD, and o_pkt_valid=1 on the next cycle (1-cycle latency).
  - HOLD: o_pkt_valid=1 and o_pkt_data is frozen. o_in_ready = i_pkt_ready, a combinational fast path.
  - Packet handshake returns the FSM to COLLECT. If an input beat is accepted in the same cycle, it becomes beat 0 of the next packet and in_cnt=1.
  - o_pkt_data keeps its last value after handoff. It is not cleared.
- Unpack FSM states: IDLE, SEND.
  - IDLE: o_res_ready=1, o_out_valid=0. An accepted result is loaded into the shift register, out_cnt is set to 0, and the FSM moves to SEND.
  - SEND: o_out_valid=1. o_out_data is the top slice (MSB_FIRST=1) or the bottom slice (MSB_FIRST=0) of the shift register.
  - Each output handshake shifts the register by DATA_W (zero fill) and increments out_cnt.
  - o_res_ready in SEND = (out_cnt==OUT_BEATS-1) & i_out_ready, so the next result loads in the same cycle as the last beat leaves. The FSM stays in SEND with out_cnt=0 and no idle cycle.
  - Last beat handshake with no new result: the FSM goes to IDLE and o_out_data returns to 0.
- The two FSMs are fully independent. Simultaneous events on both sides cause no interaction.
- Counters are $clog2(IN_BEATS) and $clog2(OUT_BEATS) bits wide, minimum 1. IN_BEATS and OUT_BEATS must be ≥1; when 1, every handshake completes a packet.

Test Plan:
- Reset, then 12 beats with MSB_FIRST=1 and valid/ready always 1; beat k = 64'h1111_1111_1111_1111*(k+1) modulo 2^64. Required: o_pkt_valid rises exactly 1 cycle after beat 11, and bits [767:704] = 64'h1111_1111_1111_1111.
- HOLD back-pressure: i_pkt_ready=0 for 5 cycles. Required: o_in_ready=0 and o_pkt_data unchanged throughout. Then raise i_pkt_ready together with i_in_valid and data 64'hA5A5_A5A5_A5A5_A5A5. Required: that beat lands in bits [767:704] of the next packet, with no lost beat.
- Unpack, i_res_data = {8 beats 64'h0 .. 64'h7} with beat 64'h0 in the MSB position, MSB_FIRST=1, i_out_ready random (seed 1). Required: o_out_data sequence is 0,1,…,7; data is held stable during stalls; o_out_data returns to 0 after IDLE.
- Back-to-back results: i_res_valid held 1 with two results, i_out_ready=1. Required: 16 consecutive output beats with o_out_valid never dropping, and o_res_ready=1 exactly on beat 7.
- Assert i_rst after 6 of 12 input beats and after 3 of 8 output beats. Required: all outputs are at reset values next cycle, and the next full 12-beat packet is packed correctly from slot 0.
- MSB_FIRST=0, DATA_W=32, IN_BEATS=3: beats 1,2,3. Required: o_pkt_data = 96'h00000003_00000002_00000001.
